// File: rtl/tanh_lut_response.sv
// tanh_lut_response
// Response side of the tanh LUT path. Accepts a classified LUT request, issues
// the read to a synchronous tanh ROM, waits out the ROM latency, then rebuilds
// the signed S1.5.6 result. The result uses odd symmetry, saturates above range,
// and handles the small-input region below range. Results queue in an in-order
// FIFO toward the LSTM activation datapath.
//
// Optional feature macro: TANH_LINEAR_REGION_EN
//   defined   : below-range requests use tanh(x) ~= x; no ROM read is issued
//   undefined : below-range requests read the ROM at the supplied address
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         request handshake
//   in_addr, in_range,          LUT request from the address calculator
//   in_sign, in_value
//   rom_en / rom_addr           ROM read strobe and address (combinational on accept)
//   rom_data                    ROM data, ROM_LATENCY cycles after rom_en
//   out_valid / out_ready       result handshake
//   out_data, out_sat           signed-magnitude result, saturation flag

module tanh_lut_response #(
   parameter int INPUT_WIDTH = 12,
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 12,
   parameter int ROM_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter logic [DATA_WIDTH-1:0] SAT_VALUE = 12'd64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_WIDTH-1:0]  in_addr,
   input  logic                   in_range,
   input  logic                   in_sign,
   input  logic [INPUT_WIDTH-1:0] in_value,
   output logic                   rom_en,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_sat
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] HI_ADDR = ADDR_WIDTH'(275);

   typedef enum logic [1:0] {
      CLS_IN = 2'd0,
      CLS_HI = 2'd1,
      CLS_LO = 2'd2
   } cls_t;

   logic accept;
   logic pop;
   cls_t in_cls;
   logic needs_rom;

   // ---------------------------------------------------------------------
   // Request classification and ROM issue
   // ---------------------------------------------------------------------
   assign accept = in_valid && in_ready;
   assign in_cls = in_range ? CLS_IN : ((in_addr == HI_ADDR) ? CLS_HI : CLS_LO);

`ifdef TANH_LINEAR_REGION_EN
   assign needs_rom = (in_cls == CLS_IN);
`else
   assign needs_rom = (in_cls != CLS_HI);
`endif

   assign rom_en   = accept && needs_rom;
   assign rom_addr = rom_en ? in_addr : '0;

   // ---------------------------------------------------------------------
   // Latency-matching pipeline: every class travels the same depth so that
   // saturated and linear results stay in issue order with ROM results.
   // ---------------------------------------------------------------------
   logic [ROM_LATENCY-1:0] pipe_vld;
   logic [ROM_LATENCY-1:0] pipe_sign;
   cls_t                   pipe_cls [ROM_LATENCY];
`ifdef TANH_LINEAR_REGION_EN
   logic [INPUT_WIDTH-2:0] pipe_val [ROM_LATENCY];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld  <= '0;
         pipe_sign <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            pipe_cls[i] <= CLS_IN;
`ifdef TANH_LINEAR_REGION_EN
            pipe_val[i] <= '0;
`endif
         end
      end else begin
         pipe_vld[0]  <= accept;
         pipe_sign[0] <= in_sign;
         pipe_cls[0]  <= in_cls;
`ifdef TANH_LINEAR_REGION_EN
         pipe_val[0]  <= in_value[INPUT_WIDTH-2:0];
`endif
         for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_sign[i] <= pipe_sign[i-1];
            pipe_cls[i]  <= pipe_cls[i-1];
`ifdef TANH_LINEAR_REGION_EN
            pipe_val[i]  <= pipe_val[i-1];
`endif
         end
      end
   end

   // ---------------------------------------------------------------------
   // Result formation at pipeline exit
   // ---------------------------------------------------------------------
   logic                  push;
   logic [DATA_WIDTH-1:0] sel;
   logic [DATA_WIDTH-2:0] mag;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_sat;
   logic                  unused_bits;

   assign push = pipe_vld[ROM_LATENCY-1];

   always_comb begin
      sel = rom_data;
      case (pipe_cls[ROM_LATENCY-1])
         CLS_HI:  sel = SAT_VALUE;
`ifdef TANH_LINEAR_REGION_EN
         CLS_LO:  sel = DATA_WIDTH'(pipe_val[ROM_LATENCY-1]);
`else
         CLS_LO:  sel = rom_data;
`endif
         default: sel = rom_data;
      endcase
   end

   assign mag      = sel[DATA_WIDTH-2:0];
   // A zero magnitude is always reported as +0.
   assign res_data = {pipe_sign[ROM_LATENCY-1] && (mag != '0), mag};
   assign res_sat  = (pipe_cls[ROM_LATENCY-1] == CLS_HI);

`ifdef TANH_LINEAR_REGION_EN
   assign unused_bits = sel[DATA_WIDTH-1] ^ in_value[INPUT_WIDTH-1];
`else
   assign unused_bits = sel[DATA_WIDTH-1] ^ (^in_value);
`endif

   // ---------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                  mem_sat  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [CNT_W-1:0]      cnt;

   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_sat   = out_valid ? mem_sat[rd_ptr]  : 1'b0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= res_data;
         mem_sat[wr_ptr]  <= res_sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   // Credits cover in-flight reads plus stored entries, so a read is only
   // issued when its FIFO slot is already reserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         if (accept && !pop)      cnt <= cnt + CNT_W'(1);
         else if (pop && !accept) cnt <= cnt - CNT_W'(1);
      end
   end

   assign in_ready = (cnt < CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_tanh_lut_response.sv
// Testbench for tanh_lut_response: directed test-plan steps followed by a
// randomized stream, checked against a queue-based reference model.

module tb_tanh_lut_response;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_addr;
   logic        in_range;
   logic        in_sign;
   logic [11:0] in_value;
   logic        rom_en;
   logic [8:0]  rom_addr;
   logic [11:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic        out_sat;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [11:0] rom_mem [512];

   typedef struct {
      logic [11:0] data;
      logic        sat;
      int          avail;
   } exp_t;

   exp_t q[$];

   tanh_lut_response dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_range  (in_range),
      .in_sign   (in_sign),
      .in_value  (in_value),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM, latency 1; returns noise when not read.
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_mem[rom_addr];
      else        rom_data <= 12'($urandom);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_hi(input logic [8:0] a, input logic r);
      return !r && (a == 9'd275);
   endfunction

   function automatic logic exp_rom_en(input logic [8:0] a, input logic r);
`ifdef TANH_LINEAR_REGION_EN
      return r;
`else
      return !is_hi(a, r);
`endif
   endfunction

   function automatic exp_t model(input logic [8:0] a, input logic r, input logic s,
                                  input logic [11:0] v, input int avail);
      exp_t e;
      logic [10:0] m;
      if (r)              m = rom_mem[a][10:0];
      else if (is_hi(a, r)) m = 11'd64;
`ifdef TANH_LINEAR_REGION_EN
      else                m = v[10:0];
`else
      else                m = rom_mem[a][10:0];
`endif
      e.data  = {s && (m != 11'd0), m};
      e.sat   = is_hi(a, r);
      e.avail = avail;
      return e;
   endfunction

   // One clock cycle: entered at a falling edge with inputs already driven.
   task automatic step(output logic acc);
      logic pop;
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      chk("in_ready", in_ready, (q.size() < 4));
      chk("out_valid", out_valid, (q.size() > 0) && (q[0].avail <= cyc));
      if (out_valid && q.size() > 0) begin
         chk("out_data", out_data, q[0].data);
         chk("out_sat", out_sat, q[0].sat);
      end
      if (acc) begin
         chk("rom_en", rom_en, exp_rom_en(in_addr, in_range));
         if (exp_rom_en(in_addr, in_range)) chk("rom_addr", rom_addr, in_addr);
      end else begin
         chk("rom_en_idle", rom_en, 1'b0);
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(model(in_addr, in_range, in_sign, in_value, cyc + 2));
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      logic acc;
      int   n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         step(acc);
         n++;
      end
      chk("drain_done", q.size(), 0);
   endtask

   task automatic one_req(input string tag, input logic [8:0] a, input logic r,
                          input logic s, input logic [11:0] v, input logic ren,
                          input logic [11:0] exp_data, input logic exp_sat);
      logic acc;
      drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_addr   = a;
      in_range  = r;
      in_sign   = s;
      in_value  = v;
      #1;
      chk({tag, "_rom_en"}, rom_en, ren);
      if (ren) chk({tag, "_rom_addr"}, rom_addr, a);
      step(acc);
      in_valid = 1'b0;
      step(acc);
      #1;
      chk({tag, "_valid_t2"}, out_valid, 1'b1);
      chk({tag, "_data"}, out_data, exp_data);
      chk({tag, "_sat"}, out_sat, exp_sat);
   endtask

   initial begin
      logic acc;
      int   accepted;

      for (int i = 0; i < 512; i++) rom_mem[i] = 12'($urandom);
      rom_mem[75]  = 12'd49;
      rom_mem[80]  = 12'd0;
      rom_mem[0]   = 12'h155;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      in_range  = 1'b0;
      in_sign   = 1'b0;
      in_value  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 12'h000);
      chk("rst_out_sat", out_sat, 1'b0);
      chk("rst_rom_en", rom_en, 1'b0);
      chk("rst_rom_addr", rom_addr, 9'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed test-plan requests
      one_req("in_pos",  9'd75,  1'b1, 1'b0, 12'd5, 1'b1, 12'h031, 1'b0);
      one_req("in_neg",  9'd75,  1'b1, 1'b1, 12'd5, 1'b1, 12'h831, 1'b0);
      one_req("in_zero", 9'd80,  1'b1, 1'b1, 12'd5, 1'b1, 12'h000, 1'b0);
      one_req("hi",      9'd275, 1'b0, 1'b1, 12'd9, 1'b0, 12'h840, 1'b1);
`ifdef TANH_LINEAR_REGION_EN
      one_req("lo",      9'd0,   1'b0, 1'b0, 12'd8, 1'b0, 12'h008, 1'b0);
`else
      one_req("lo",      9'd0,   1'b0, 1'b0, 12'd8, 1'b1, 12'h155, 1'b0);
`endif

      // Backpressure: 6 back-to-back offers with the consumer stalled
      drain();
      out_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_addr  = 9'(100 + i);
         in_range = 1'b1;
         in_sign  = i[0];
         in_value = 12'(i);
         step(acc);
         if (acc) accepted++;
      end
      #1;
      chk("bp_accepted", accepted, 4);
      chk("bp_in_ready", in_ready, 1'b0);
      in_valid  = 1'b0;
      drain();
      accepted = 0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_addr  = 9'(104 + i);
         step(acc);
         if (acc) accepted++;
      end
      chk("bp_resume_accepted", accepted, 2);
      drain();

      // Reset with three reads in flight / stored
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_addr  = 9'(200 + i);
         in_range = 1'b1;
         in_sign  = 1'b1;
         step(acc);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_rom_en", rom_en, 1'b0);
      q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step(acc);

      // Randomized stream
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_range  = $urandom_range(1);
         in_addr   = ($urandom_range(3) == 0) ? 9'd275 : 9'($urandom);
         in_sign   = $urandom_range(1);
         in_value  = 12'($urandom);
         step(acc);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tanh_lut_response.md
# tanh_lut_response

Response-side companion to the tanh address calculator. It accepts a LUT request (address, range flag, sign, raw input), issues the read to the synchronous tanh ROM and waits out the ROM latency. It then reconstructs the signed tanh result using odd symmetry, saturation above range and the small-input region below range. Results are buffered in an in-order output FIFO with valid/ready flow control toward the LSTM activation datapath.

## Interface
- INPUT_WIDTH, 12, raw input width, S1.5.6 sign-magnitude
- ADDR_WIDTH, 9, LUT address width
- DATA_WIDTH, 12, ROM word width (unsigned magnitude, x64 scaling)
- ROM_LATENCY, 1, cycles from rom_en to rom_data valid (1 or 2)
- FIFO_DEPTH, 4, output buffer entries (power of two, >= ROM_LATENCY+1)
- SAT_VALUE, 12'd64, magnitude emitted above range (1.0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_addr  in  ADDR_WIDTH  LUT address from calculator
- in_range  in  1  1 = address within LUT range
- in_sign  in  1  input sign bit
- in_value  in  INPUT_WIDTH  raw input (used for the linear region)
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM read data, ROM_LATENCY cycles after rom_en
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_WIDTH  tanh result, S1.5.6 sign-magnitude
- out_sat  out  1  result was saturated (above range)

## Operation
- Request classes:
  - IN: in_range=1. Result magnitude is rom_data.
  - HI: in_range=0 and in_addr=275. Result magnitude is SAT_VALUE; out_sat=1.
  - LO: in_range=0 and any other address. Handling is set under Configuration.
- On accept, rom_en=1 and rom_addr=in_addr are driven combinationally in the same cycle, for IN (and for LO without the macro). rom_en stays 0 for HI and for every non-accepting cycle.
- Class, sign and in_value travel through a ROM_LATENCY-deep valid-tagged shift pipeline, so all classes keep issue order.
- At pipeline exit, the result is formed as follows:
  - magnitude = selected value, truncated to DATA_WIDTH-1 bits
  - sign bit = in_sign, forced to 0 when the magnitude is 0 (no negative zero)
- The formed result is pushed into the FIFO.
- Credit counter cnt = in-flight + stored entries, range 0..FIFO_DEPTH.
  - cnt increments on accept and decrements on pop; it is unchanged when both occur in the same cycle.
  - in_ready = (cnt < FIFO_DEPTH). This guarantees every issued read has a FIFO slot.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop at full is legal because the pop frees the slot.
- Pop on empty never occurs, since out_valid=0 when empty.
- out_data and out_sat come from the FIFO head and are stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, rom_en=0, rom_addr=0, cnt=0 (so in_ready=1), pipeline valids=0, FIFO pointers=0.
- Reset assertion clears all state immediately. In-flight reads are discarded; ROM data returning after reset is ignored.
- Latency: accept at cycle T, result in FIFO at cycle T+ROM_LATENCY, out_valid high from T+ROM_LATENCY+1 when the FIFO was empty.
- Throughput: one request per cycle while out_ready=1.
- in_ready depends only on registered cnt. It has no combinational path from out_ready.

## Configuration
- TANH_LINEAR_REGION_EN:
  - Defined: LO results use magnitude = in_value[INPUT_WIDTH-2:0] (tanh(x) ≈ x), and no ROM read is issued.
  - Undefined: LO issues a ROM read at in_addr and uses rom_data.

## Test plan
- IN, sign 0: in_addr=75, in_range=1, ROM returns 12'd49 -> rom_en pulse with rom_addr=75; out_data=12'h031 and out_sat=0, with out_valid at T+2 (ROM_LATENCY=1).
- IN, sign 1: same request with in_sign=1 -> out_data=12'h831. Zero check: sign 1 with rom_data=0 -> out_data=12'h000.
- HI: in_addr=275, in_range=0, in_sign=1 -> rom_en stays 0; out_data=12'h840 and out_sat=1.
- LO: in_value=12'd8 -> with the macro, out_data=12'h008 and no rom_en; without it, rom_addr=0 and out_data=rom_data.
- Backpressure: out_ready=0, offer 6 back-to-back requests -> exactly 4 accepted and in_ready=0. Then raise out_ready -> 4 results in issue order, after which the remaining requests are accepted.
- Reset mid-flight: 3 requests in flight, pulse rst_n low -> out_valid=0 immediately and in_ready=1 after release; no stale results ever appear.
